cube_state_assembler: RTL and testbench

CUBE_STATE_ASSEMBLER -- requirements
Module: cube_state_assembler

---
 rtl/cube_state_assembler.sv | 179 +++++++++++++++++
 tb/tb_cube_state_assembler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cube_state_assembler.sv
// cube_state_assembler
//   Collects a 15-byte frame into a 120-bit shadow register, validates the
//   cube-state fields, and presents the state on d with a one-cycle load
//   strobe. Malformed or invalid frames produce a one-cycle frame_err strobe
//   with a cause code that is held until the next frame starts.
//
//   Ports
//     clk        in   clock, rising edge
//     rst        in   asynchronous active-high reset
//     in_valid   in   upstream byte valid
//     in_data    in   upstream byte [7:0]
//     in_last    in   final byte of frame (qualified by in_valid)
//     in_ready   out  byte accepted when in_valid && in_ready
//     load       out  one-cycle strobe: d holds a validated state
//     d          out  packed state [119:0]
//                       [35:0]    12 x 3b corner position
//                       [59:36]   12 x 2b corner direction
//                       [107:60]  12 x 4b edge position
//                       [119:108] 12 x 1b edge direction
//     frame_err  out  one-cycle strobe on frame rejection
//     err_code   out  cause of last rejection
//                       1 short, 2 long, 3 field range, 4 duplicate edge,
//                       5 edge parity, 6 inter-byte timeout
module cube_state_assembler #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         load,
    output logic [119:0] d,
    output logic         frame_err,
    output logic [2:0]   err_code
);

    // Counter only needs to reach TIMEOUT_CYC-1; the expiring cycle is
    // detected by comparison rather than by counting to TIMEOUT_CYC.
    localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

    localparam logic [2:0] ERR_SHORT   = 3'd1;
    localparam logic [2:0] ERR_LONG    = 3'd2;
    localparam logic [2:0] ERR_RANGE   = 3'd3;
    localparam logic [2:0] ERR_DUP     = 3'd4;
    localparam logic [2:0] ERR_PARITY  = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        DROP,
        CHECK,
        DONE
    } state_t;

    state_t          state_q;
    logic [119:0]    shadow_q;
    logic [119:0]    d_q;
    logic [3:0]      cnt_q;
    logic [TW-1:0]   tcnt_q;
    logic            load_q;
    logic            frame_err_q;
    logic [2:0]      err_code_q;

    logic            accept;
    logic            cdir_bad;
    logic            epos_bad;
    logic            epos_dup;
    logic            edir_bad;
    logic [2:0]      chk_code;

    assign in_ready  = (state_q == IDLE) || (state_q == RECV) || (state_q == DROP);
    assign accept    = in_valid && in_ready;
    assign load      = load_q;
    assign d         = d_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;

    // Field validation of the shadow register, first failure wins.
    always_comb begin
        cdir_bad = 1'b0;
        epos_bad = 1'b0;
        epos_dup = 1'b0;
        for (int unsigned i = 0; i < 12; i++) begin
            if (shadow_q[36 + 2*i +: 2] == 2'd3) cdir_bad = 1'b1;
            if (shadow_q[60 + 4*i +: 4] >= 4'd12) epos_bad = 1'b1;
            for (int unsigned j = i + 1; j < 12; j++) begin
                if (shadow_q[60 + 4*i +: 4] == shadow_q[60 + 4*j +: 4]) epos_dup = 1'b1;
            end
        end
        edir_bad = ^shadow_q[119:108];

        chk_code = '0;
        if (cdir_bad || epos_bad) chk_code = ERR_RANGE;
        else if (epos_dup)        chk_code = ERR_DUP;
        else if (edir_bad)        chk_code = ERR_PARITY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            load_q      <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            load_q      <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shadow_q[7:0] <= in_data;
                        if (in_last) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_SHORT;
                        end else begin
                            err_code_q <= '0;
                            cnt_q      <= 4'd1;
                            tcnt_q     <= '0;
                            state_q    <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (accept) begin
                        shadow_q[{cnt_q, 3'b000} +: 8] <= in_data;
                        tcnt_q <= '0;
                        cnt_q  <= cnt_q + 4'd1;
                        if (cnt_q == 4'd14) begin
                            if (in_last) begin
                                state_q <= CHECK;
                            end else begin
                                frame_err_q <= 1'b1;
                                err_code_q  <= ERR_LONG;
                                state_q     <= DROP;
                            end
                        end else if (in_last) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_SHORT;
                            state_q     <= IDLE;
                        end
                    end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                        frame_err_q <= 1'b1;
                        err_code_q  <= ERR_TIMEOUT;
                        state_q     <= IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                DROP: begin
                    if (accept && in_last) state_q <= IDLE;
                end
                CHECK: begin
                    if (chk_code != 3'd0) begin
                        frame_err_q <= 1'b1;
                        err_code_q  <= chk_code;
                        state_q     <= IDLE;
                    end else begin
                        d_q     <= shadow_q;
                        load_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cube_state_assembler.sv
// Testbench for cube_state_assembler: directed frames plus randomized cube
// states, checked by a scoreboard of expected load / frame_err events built
// from a behavioural field model.
module tb_cube_state_assembler;

    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = '0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic         load;
    logic [119:0] d;
    logic         frame_err;
    logic [2:0]   err_code;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    typedef struct {
        int           cyc;
        bit           is_load;
        logic [119:0] val;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];

    logic [119:0] model_d = '0;
    logic [2:0]   model_code = '0;

    cube_state_assembler #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .load      (load),
        .d         (d),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed output events, stamped with the number of clock edges so far.
    always @(negedge clk) begin
        if (!rst && (load || frame_err)) begin
            obs_q.push_back(ev_t'{cyc, bit'(load), load ? d : {117'b0, err_code}});
            check_val("load_with_err", 128'(load & frame_err), 128'(0));
        end
    end

    // Behavioural field validation: priority range > duplicate > parity.
    function automatic logic [2:0] field_code(input logic [119:0] s);
        int ep[12];
        int seen[16];
        logic [119:0] t;
        bit bad3 = 0;
        bit dup = 0;
        foreach (seen[k]) seen[k] = 0;
        for (int i = 0; i < 12; i++) begin
            t = s >> (36 + 2*i);
            if (int'(t[1:0]) == 3) bad3 = 1;
            t = s >> (60 + 4*i);
            ep[i] = int'(t[3:0]);
            if (ep[i] >= 12) bad3 = 1;
            seen[ep[i]]++;
        end
        foreach (seen[k]) if (seen[k] > 1) dup = 1;
        if (bad3) return 3'd3;
        if (dup) return 3'd4;
        if (($countones(s[119:108]) % 2) == 1) return 3'd5;
        return 3'd0;
    endfunction

    // Legal cube state (permuted edges, even edge parity), optionally corrupted.
    function automatic logic [119:0] gen_cube(input int mut);
        int p[12];
        int tmp, j, k, k2;
        logic [119:0] s = '0;
        for (int i = 0; i < 12; i++) p[i] = i;
        for (int i = 11; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = p[i]; p[i] = p[j]; p[j] = tmp;
        end
        for (int i = 0; i < 12; i++) begin
            s[3*i +: 3]      = 3'($urandom);
            s[36 + 2*i +: 2] = 2'($urandom_range(0, 2));
            s[60 + 4*i +: 4] = 4'(p[i]);
            s[108 + i]       = 1'($urandom);
        end
        if (($countones(s[119:108]) % 2) == 1) s[119] = ~s[119];
        k  = $urandom_range(0, 11);
        k2 = (k + $urandom_range(1, 11)) % 12;
        case (mut)
            1: s[36 + 2*k +: 2] = 2'd3;
            2: s[60 + 4*k +: 4] = 4'($urandom_range(12, 15));
            3: s[60 + 4*k2 +: 4] = s[60 + 4*k +: 4];
            4: s[108 + k] = ~s[108 + k];
            default: ;
        endcase
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit last, input int gap, output int acc);
        int tries = 0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        while (!in_ready && tries < 40) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) begin
            check_val("ready_wait", 128'(in_ready), 128'(1));
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // kind 0: in_last on final byte; 1: no in_last (timeout expected);
    // 2: no in_last, aborted by the caller (no outcome expected).
    task automatic send_frame(input logic [119:0] sh, input int n, input int kind,
                              input int maxgap, input int fixed_k, input int fixed_gap,
                              output int fa, output int la);
        int acc[32];
        int gap;
        logic [7:0] b;
        logic [2:0] c;
        for (int k = 0; k < n; k++) begin
            b = (k < 15) ? sh[8*k +: 8] : 8'($urandom);
            gap = (k == 0) ? 0 : (k == fixed_k) ? fixed_gap : $urandom_range(0, maxgap);
            send_byte(b, (kind == 0) && (k == n - 1), gap, acc[k]);
        end
        fa = acc[0];
        la = acc[n-1];
        if (kind == 0) begin
            if (n < 15) begin
                exp_q.push_back(ev_t'{acc[n-1], 1'b0, 120'(1)});
                model_code = 3'd1;
            end else if (n == 15) begin
                c = field_code(sh);
                if (c != 3'd0) begin
                    exp_q.push_back(ev_t'{acc[14] + 1, 1'b0, 120'(c)});
                end else begin
                    exp_q.push_back(ev_t'{acc[14] + 1, 1'b1, sh});
                    model_d = sh;
                end
                model_code = c;
            end else begin
                exp_q.push_back(ev_t'{acc[14], 1'b0, 120'(2)});
                model_code = 3'd2;
            end
        end else if (kind == 1) begin
            exp_q.push_back(ev_t'{acc[n-1] + TO, 1'b0, 120'(6)});
            model_code = 3'd6;
        end
    endtask

    task automatic compare_events();
        ev_t e, o;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check_val("evt_cycle", 128'(o.cyc), 128'(e.cyc));
            check_val("evt_is_load", 128'(o.is_load), 128'(e.is_load));
            check_val("evt_value", 128'(o.val), 128'(e.val));
        end
        check_val("evt_unmatched_obs", 128'(obs_q.size()), 128'(0));
        check_val("evt_unmatched_exp", 128'(exp_q.size()), 128'(0));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
        compare_events();
        check_val("d_hold", 128'(d), 128'(model_d));
        check_val("err_code_hold", 128'(err_code), 128'(model_code));
        check_val("ready_idle", 128'(in_ready), 128'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_d"}, 128'(d), 128'(0));
        check_val({tag, "_load"}, 128'(load), 128'(0));
        check_val({tag, "_frame_err"}, 128'(frame_err), 128'(0));
        check_val({tag, "_err_code"}, 128'(err_code), 128'(0));
        check_val({tag, "_ready"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [119:0] solved, s;
        int fa, la, fa2, la2, mut, r, n;

        solved = '0;
        for (int i = 0; i < 12; i++) solved[60 + 4*i +: 4] = 4'(i);

        // Asynchronous reset, checked before any clock edge.
        #1 rst = 1'b1;
        #2 check_reset_outputs("rst_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check_val("ready_after_rst", 128'(in_ready), 128'(1));

        // Solved cube.
        send_frame(solved, 15, 0, 0, -1, 0, fa, la);
        settle(5);
        check_val("solved_d", 128'(d), 128'({12'h0, 48'hBA9876543210, 60'h0}));
        check_val("solved_code", 128'(err_code), 128'(0));

        // Back-to-back frames: upstream stalls through CHECK/DONE.
        send_frame(gen_cube(0), 15, 0, 2, -1, 0, fa, la);
        send_frame(gen_cube(0), 15, 0, 2, -1, 0, fa2, la2);
        check_val("b2b_after_load", 128'(fa2), 128'(la + 3));
        send_frame(gen_cube(1), 15, 0, 2, -1, 0, fa, la);
        send_frame(gen_cube(0), 15, 0, 2, -1, 0, fa2, la2);
        check_val("b2b_after_chkerr", 128'(fa2), 128'(la + 2));
        settle(5);

        // Short frames, including a lone last byte.
        send_frame(gen_cube(0), 10, 0, 1, -1, 0, fa, la);
        settle(5);
        check_val("short10_code", 128'(err_code), 128'(1));
        send_frame(gen_cube(0), 1, 0, 0, -1, 0, fa, la);
        settle(5);

        // Long frame followed by a good frame.
        send_frame(gen_cube(0), 17, 0, 1, -1, 0, fa, la);
        settle(3);
        check_val("long_code", 128'(err_code), 128'(2));
        send_frame(gen_cube(0), 15, 0, 1, -1, 0, fa, la);
        settle(5);

        // Field errors.
        s = solved; s[36 +: 2] = 2'd3;
        send_frame(s, 15, 0, 0, -1, 0, fa, la);
        settle(5);
        check_val("cdir3_code", 128'(err_code), 128'(3));
        s = solved; s[60 + 4*3 +: 4] = 4'd12;
        send_frame(s, 15, 0, 0, -1, 0, fa, la);
        settle(5);
        s = solved; s[60 +: 4] = 4'd5; s[64 +: 4] = 4'd5;
        send_frame(s, 15, 0, 0, -1, 0, fa, la);
        settle(5);
        check_val("dup_code", 128'(err_code), 128'(4));
        s = solved; s[108] = 1'b1;
        send_frame(s, 15, 0, 0, -1, 0, fa, la);
        settle(5);
        check_val("parity_code", 128'(err_code), 128'(5));

        // Gap of TO-1 idle cycles must not time out; TO must.
        send_frame(gen_cube(0), 15, 0, 0, 5, TO - 1, fa, la);
        settle(5);
        send_frame(gen_cube(0), 4, 1, 0, -1, 0, fa, la);
        settle(TO + 4);
        check_val("timeout_code", 128'(err_code), 128'(6));
        send_frame(gen_cube(0), 15, 0, 0, -1, 0, fa, la);
        settle(5);

        // Reset mid-frame after byte 7.
        send_frame(gen_cube(0), 8, 2, 2, -1, 0, fa, la);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        model_d = '0;
        model_code = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        settle(20);
        send_frame(gen_cube(0), 15, 0, 1, -1, 0, fa, la);
        settle(5);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            mut = $urandom_range(0, 8);
            if (mut > 4) mut = 0;
            r = $urandom_range(0, 9);
            n = (r == 0) ? $urandom_range(1, 14) : (r == 1) ? $urandom_range(16, 18) : 15;
            send_frame(gen_cube(mut), n, 0, TO - 1, -1, 0, fa, la);
            if ($urandom_range(0, 1) == 1) settle(4);
        end
        settle(6);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
